// File: rtl/lif_array_pkg.sv
// Shared types and helpers for the LIF potential array: sweep state encoding,
// the saturating adder used on both the weight path and the neuron datapath.
package lif_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } lif_state_t;

    // 40.0 in Q8.8
    localparam logic [15:0] LIF_VTH_DEFAULT = 16'h2800;

    // Operands arrive sign-extended to 64 bits; the result is clamped to the
    // signed range of a w-bit word, so truncating it to w bits never wraps.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (w - 1));
        if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        return sum;
    endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational LIF step for one neuron: leak, saturating integrate,
// threshold compare and reset-by-subtraction.
module lif_neuron_update
    import lif_array_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] v,
    input  logic signed [WIDTH-1:0] acc,
    input  logic signed [WIDTH-1:0] threshold,
    input  logic        [3:0]       shift,
    output logic signed [WIDTH-1:0] v_next,
    output logic                    fire
);

    logic signed [WIDTH-1:0] leak;
    logic signed [WIDTH-1:0] decayed;
    logic signed [WIDTH-1:0] summed;

    // v - (v >>> k) stays in range for any v and k, so only the add saturates.
    // With a positive threshold, summed - threshold cannot overflow either.
    always_comb begin
        leak    = v >>> shift;
        decayed = v - leak;
        summed  = WIDTH'(sat_add(64'(decayed), 64'(acc), WIDTH));
        fire    = (summed >= threshold);
        v_next  = fire ? (summed - threshold) : summed;
    end

endmodule

// File: rtl/lif_potential_array.sv
// Time-multiplexed LIF potential engine: per-neuron weight accumulation while
// idle, then a one-neuron-per-cycle sweep. Optional refractory: LIF_REFRACTORY_EN.
module lif_potential_array
    import lif_array_pkg::*;
#(
    parameter int NEURONS   = 32,
    parameter int WIDTH     = 16,
    parameter int FRAC      = 8,
    parameter int ID_W      = $clog2(NEURONS),
    parameter int REF_STEPS = 2
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] v_threshold,
    input  logic        [3:0]       decay_shift,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic        [ID_W-1:0]  w_id,
    input  logic signed [WIDTH-1:0] w_data,
    input  logic                    update_start,
    output logic                    spike_valid,
    output logic        [ID_W-1:0]  spike_id,
    output logic                    busy,
    output logic                    done,
    input  logic        [ID_W-1:0]  rd_id,
    output logic signed [WIDTH-1:0] rd_potential
);

    lif_state_t                       state;
    logic        [ID_W-1:0]           idx;
    logic signed [WIDTH-1:0]          th_q;
    logic        [3:0]                shift_q;
    logic [NEURONS-1:0][WIDTH-1:0]    v_mem;
    logic [NEURONS-1:0][WIDTH-1:0]    acc_mem;

    logic signed [WIDTH-1:0]          cur_v;
    logic signed [WIDTH-1:0]          cur_acc;
    logic signed [WIDTH-1:0]          v_next;
    logic                             fire;
    logic                             last_idx;
    logic                             w_in_range;
    logic                             unused_cfg;

    // FRAC is only a format annotation; the datapath is plain integer.
    assign unused_cfg = (FRAC < WIDTH) ^ (REF_STEPS > 0);

    assign cur_v      = $signed(v_mem[idx]);
    assign cur_acc    = $signed(acc_mem[idx]);
    assign last_idx   = (idx == ID_W'(NEURONS - 1));
    assign w_in_range = (int'(w_id) < NEURONS);

    assign rd_potential = (int'(rd_id) < NEURONS) ? $signed(v_mem[rd_id]) : '0;

    lif_neuron_update #(
        .WIDTH (WIDTH)
    ) u_update (
        .v         (cur_v),
        .acc       (cur_acc),
        .threshold (th_q),
        .shift     (shift_q),
        .v_next    (v_next),
        .fire      (fire)
    );

`ifdef LIF_REFRACTORY_EN
    localparam int RC_W = (REF_STEPS < 1) ? 1 : $clog2(REF_STEPS + 1);
    logic [NEURONS-1:0][RC_W-1:0] ref_cnt;
    logic                         in_ref;
    assign in_ref = (ref_cnt[idx] != '0);
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            th_q        <= '0;
            shift_q     <= '0;
            v_mem       <= '0;
            acc_mem     <= '0;
            w_ready     <= 1'b1;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef LIF_REFRACTORY_EN
            ref_cnt     <= '0;
`endif
        end else begin
            spike_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Out-of-range targets are accepted and dropped.
                    if (w_valid && w_in_range)
                        acc_mem[w_id] <= WIDTH'(sat_add(64'($signed(acc_mem[w_id])),
                                                        64'(w_data), WIDTH));
                    if (update_start) begin
                        th_q    <= v_threshold;
                        shift_q <= decay_shift;
                        idx     <= '0;
                        state   <= ST_UPDATE;
                        busy    <= 1'b1;
                        w_ready <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    acc_mem[idx] <= '0;
`ifdef LIF_REFRACTORY_EN
                    if (in_ref) begin
                        v_mem[idx]   <= '0;
                        ref_cnt[idx] <= ref_cnt[idx] - 1'b1;
                    end else begin
                        v_mem[idx] <= v_next;
                        if (fire) begin
                            ref_cnt[idx] <= RC_W'(REF_STEPS);
                            spike_valid  <= 1'b1;
                            spike_id     <= idx;
                        end
                    end
`else
                    v_mem[idx] <= v_next;
                    if (fire) begin
                        spike_valid <= 1'b1;
                        spike_id    <= idx;
                    end
`endif
                    if (last_idx) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    w_ready <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    w_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_potential_array.sv
// Directed plus randomized bench for lif_potential_array against a plain
// arithmetic LIF model (floor-division leak, clamped integer sums).
module tb_lif_potential_array;

    localparam int N     = 32;
    localparam int W     = 16;
    localparam int IDW   = $clog2(N);
    localparam int REF   = 2;
    localparam int VMAX  = (1 << (W - 1)) - 1;
    localparam int VMIN  = -(1 << (W - 1));
    localparam int MASK  = (1 << W) - 1;

    logic           CLK = 1'b0;
    logic           reset;
    logic [W-1:0]   v_threshold;
    logic [3:0]     decay_shift;
    logic           w_valid;
    logic           w_ready;
    logic [IDW-1:0] w_id;
    logic [W-1:0]   w_data;
    logic           update_start;
    logic           spike_valid;
    logic [IDW-1:0] spike_id;
    logic           busy;
    logic           done;
    logic [IDW-1:0] rd_id;
    logic [W-1:0]   rd_potential;

    int checks   = 0;
    int failures = 0;

    int v_m   [N];
    int acc_m [N];
    int rc_m  [N];

    always #5 CLK = ~CLK;

    lif_potential_array #(
        .NEURONS   (N),
        .WIDTH     (W),
        .FRAC      (8),
        .ID_W      (IDW),
        .REF_STEPS (REF)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .v_threshold  (v_threshold),
        .decay_shift  (decay_shift),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_id         (w_id),
        .w_data       (w_data),
        .update_start (update_start),
        .spike_valid  (spike_valid),
        .spike_id     (spike_id),
        .busy         (busy),
        .done         (done),
        .rd_id        (rd_id),
        .rd_potential (rd_potential)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    // v minus floor(v / 2^sh)
    function automatic int leaked(input int v, input int sh);
        int p;
        int q;
        p = 1 << sh;
        q = v / p;
        if (v < 0 && (v % p) != 0) q = q - 1;
        return v - q;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            v_m[i] = 0; acc_m[i] = 0; rc_m[i] = 0;
        end
    endtask

    task automatic model_weight(input int id, input logic [W-1:0] d);
        if (id < N) acc_m[id] = sat(acc_m[id] + int'($signed(d)));
    endtask

    task automatic model_sweep(input int th, input int sh, output logic [N-1:0] m);
        int s;
        m = '0;
        for (int i = 0; i < N; i++) begin
`ifdef LIF_REFRACTORY_EN
            if (rc_m[i] != 0) begin
                rc_m[i]--; v_m[i] = 0; acc_m[i] = 0;
                continue;
            end
`endif
            s = sat(leaked(v_m[i], sh) + acc_m[i]);
            acc_m[i] = 0;
            if (s >= th) begin
                v_m[i] = s - th; m[i] = 1'b1; rc_m[i] = REF;
            end else begin
                v_m[i] = s;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_w(input int id, input logic [W-1:0] d);
        w_valid = 1'b1; w_id = IDW'(id); w_data = d;
        model_weight(id, d);
        step();
        w_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_id = IDW'(i);
            #1;
            chk($sformatf("%s_pot%0d", tag, i), 32'(rd_potential), v_m[i] & MASK);
        end
    endtask

    // Pulses update_start at cycle T and checks every cycle T+1..T+N+3.
    task automatic sweep(input string tag, input int th, input int sh,
                         input bit with_w, input int wid, input logic [W-1:0] wd,
                         input bit second_start, output logic [N-1:0] fired);
        logic [N-1:0] exp_m;
        logic         exp_sv;
        fired = '0;
        v_threshold = W'(th); decay_shift = 4'(sh); update_start = 1'b1;
        if (with_w) begin
            w_valid = 1'b1; w_id = IDW'(wid); w_data = wd;
            model_weight(wid, wd);
        end
        model_sweep(th, sh, exp_m);
        for (int k = 1; k <= N + 3; k++) begin
            step();
            if (k == 1) begin update_start = 1'b0; w_valid = 1'b0; end
            if (second_start && k == 5) begin
                update_start = 1'b1; v_threshold = 16'h0001; decay_shift = 4'd3;
            end
            if (k == 6) update_start = 1'b0;
            chk($sformatf("%s_busy_T%0d", tag, k), 32'(busy), 32'(k <= N));
            chk($sformatf("%s_done_T%0d", tag, k), 32'(done), 32'(k == N + 1));
            chk($sformatf("%s_wready_T%0d", tag, k), 32'(w_ready), 32'(k >= N + 2));
            exp_sv = (k >= 2 && k <= N + 1) ? exp_m[k-2] : 1'b0;
            chk($sformatf("%s_sv_T%0d", tag, k), 32'(spike_valid), 32'(exp_sv));
            if (spike_valid === 1'b1) fired[spike_id] = 1'b1;
            if (exp_sv) chk($sformatf("%s_sid_T%0d", tag, k), 32'(spike_id), 32'(k - 2));
        end
        check_all(tag);
    endtask

    logic [N-1:0] f;
    int           nw;
    int           pat [4];

    initial begin
        reset = 1'b1; v_threshold = '0; decay_shift = '0; w_valid = 1'b0;
        w_id = '0; w_data = '0; update_start = 1'b0; rd_id = '0;
        model_clear();
        step(); step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_wready", 32'(w_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sv", 32'(spike_valid), 32'd0);
        chk("rst_sid", 32'(spike_id), 32'd0);
        check_all("rst");

        // Integrate and fire on neuron 3
        send_w(3, 16'h1800);
        send_w(3, 16'h1800);
        sweep("fire3", 32'h2800, 0, 1'b0, 0, '0, 1'b0, f);
        rd_id = 3; #1;
        chk("fire3_pot", 32'(rd_potential), 32'h0800);
        chk("fire3_mask", 32'(f), 32'h8);

        // Leak only on neuron 0
        send_w(0, 16'h1000);
        sweep("load0", 32'h7FFF, 0, 1'b0, 0, '0, 1'b0, f);
        sweep("leak0", 32'h7FFF, 1, 1'b0, 0, '0, 1'b0, f);
        rd_id = 0; #1;
        chk("leak0_pot", 32'(rd_potential), 32'h0800);
        chk("leak0_nospike", 32'(f), 32'h0);

        // Saturating accumulation on neuron 5
        reset = 1'b1; step(); reset = 1'b0; model_clear();
        for (int i = 0; i < 4; i++) send_w(5, 16'h7000);
        sweep("sat5", 32'h7FFF, 0, 1'b0, 0, '0, 1'b0, f);
        rd_id = 5; #1;
        chk("sat5_pot", 32'(rd_potential), 32'h0);
        chk("sat5_mask", 32'(f), 32'h20);

        // Weight alongside update_start counts; a second start mid-sweep is ignored
        sweep("hs", 32'h0100, 0, 1'b1, 9, 16'h0180, 1'b1, f);
        chk("hs_w9_fired", 32'(f[9]), 32'd1);
        step();
        chk("hs_idle_busy", 32'(busy), 32'd0);
        chk("hs_idle_wready", 32'(w_ready), 32'd1);

        // Randomized timesteps
        for (int r = 0; r < 8; r++) begin
            nw = $urandom_range(0, 24);
            for (int j = 0; j < nw; j++)
                send_w($urandom_range(0, N - 1),
                       (j % 5 == 0) ? W'($urandom) : W'($urandom_range(0, 16'h3000)));
            sweep($sformatf("rnd%0d", r), $urandom_range(1, VMAX),
                  $urandom_range(0, 15), 1'b1, $urandom_range(0, N - 1),
                  W'($urandom_range(0, 16'h2000)), 1'b0, f);
        end

        // Reset mid-sweep: no done pulse, everything cleared
        for (int i = 0; i < 6; i++) send_w(i * 5, 16'h2000);
        v_threshold = 16'h1000; decay_shift = 4'd0; update_start = 1'b1;
        step();
        update_start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        nw = 0;
        for (int k = 0; k < N + 6; k++) begin
            step();
            if (done === 1'b1) nw++;
        end
        chk("midrst_no_done", 32'(nw), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wready", 32'(w_ready), 32'd1);
        check_all("midrst");

        // Constant drive on neuron 7 across four timesteps
`ifdef LIF_REFRACTORY_EN
        pat = '{1, 0, 0, 1};
`else
        pat = '{1, 1, 1, 1};
`endif
        for (int s = 0; s < 4; s++) begin
            send_w(7, 16'h3000);
            sweep($sformatf("ref%0d", s), 32'h2800, 0, 1'b0, 0, '0, 1'b0, f);
            chk($sformatf("ref_step%0d_fire7", s + 1), 32'(f[7]), 32'(pat[s]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
